// File: rtl/led_pkg.sv
// led_pkg: state/rate encodings and divisor helper shared by the LED run controller.
package led_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;
  localparam logic [1:0] RATE_1K  = 2'b00;
  localparam logic [1:0] RATE_100 = 2'b01;
  localparam logic [1:0] RATE_20  = 2'b10;
  localparam logic [1:0] RATE_5   = 2'b11;
  localparam logic DIR_LEFT = 1'b1;
  function automatic logic [24:0] rate_div(input logic [1:0] code, input int clk_hz);
    int hz;
    hz = code == RATE_1K ? 1000 : code == RATE_100 ? 100 : code == RATE_20 ? 20 : 5;
    return 25'(clk_hz / hz);
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser, stability counter and registered rising-edge pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);
  localparam int W = $clog2(DEB_CYCLES + 1);
  logic [1:0]   sync_q;
  logic [W-1:0] cnt_q, cnt_d;
  logic         level_q, level_d, rise_q;
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == W'(DEB_CYCLES - 1)) level_d = ~level_q;
      else cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], din};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
    end
  end
  assign level = level_q;
  assign rise  = rise_q;
endmodule

// File: rtl/led_run_ctrl.sv
// led_run_ctrl: debounced run/pause FSM and rate divider producing shift strobes for the LED shifter.
module led_run_ctrl
  import led_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic [1:0] freq_set,
  input  logic       dir_set,
  output logic       shift_en,
  output logic       shift_dir,
  output logic [1:0] state,
  output logic       run
);
  state_t      state_q, state_d;
  logic [1:0]  fs1_q, fs2_q, freq_q;
  logic        ds_q, dir_q, en_q, en_d;
  logic [24:0] cnt_q, cnt_d, div;
  logic        deb_level, deb_rise, press, chg, tc;
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk  (clk),
    .rst  (rst),
    .din  (button),
    .level(deb_level),
    .rise (deb_rise)
  );
  assign press = deb_rise & deb_level;
  // divisor follows the registered copy, so a new rate applies the cycle after the change
  always_comb begin
    div     = rate_div(freq_q, CLK_HZ);
    chg     = fs2_q != freq_q;
    tc      = cnt_q == div - 25'd1;
    state_d = !press ? state_q : state_q == RUN ? PAUSE : RUN;
    en_d    = state_q == RUN && !press && !chg && tc;
    cnt_d   = (state_q != RUN || press || chg || tc) ? '0 : cnt_q + 25'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fs1_q   <= '0;
      fs2_q   <= '0;
      freq_q  <= RATE_1K;
      ds_q    <= 1'b0;
      dir_q   <= DIR_LEFT;
      en_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fs1_q   <= freq_set;
      fs2_q   <= fs1_q;
      freq_q  <= fs2_q;
      ds_q    <= dir_set;
      dir_q   <= ds_q;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
    end
  end
  assign shift_en  = en_q;
  assign shift_dir = dir_q;
  assign state     = state_q;
  assign run       = state_q == RUN;
endmodule

// File: tb/tb_led_run_ctrl.sv
// tb_led_run_ctrl: directed checks of debounce, run/pause, rate change, direction and collisions.
module tb_led_run_ctrl;
  logic       clk = 1'b0, rst = 1'b1, button = 1'b0, dir_set = 1'b1;
  logic [1:0] freq_set = 2'b00;
  logic       shift_en, shift_dir, run;
  logic [1:0] state;
  int n_chk = 0, n_fail = 0;
  int n, c;
  led_run_ctrl #(.CLK_HZ(10_000), .DEB_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .button   (button),
    .freq_set (freq_set),
    .dir_set  (dir_set),
    .shift_en (shift_en),
    .shift_dir(shift_dir),
    .state    (state),
    .run      (run)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_strobe(input int max, output int k);
    k = 0;
    do begin
      step(1);
      k++;
    end while (!shift_en && k < max);
  endtask
  task automatic count_strobes(input int cycles, output int k);
    k = 0;
    repeat (cycles) begin
      step(1);
      if (shift_en) k++;
    end
  endtask
  task automatic press_btn();
    button = 1'b1;
    step(10);
    button = 1'b0;
    step(10);
  endtask
  initial begin
    // reset and idle
    step(5);
    check("rst_state", state, 0);
    check("rst_en", shift_en, 0);
    rst = 1'b0;
    count_strobes(200, c);
    check("idle_strobes", c, 0);
    check("idle_state", state, 0);
    check("idle_dir", shift_dir, 1);
    check("idle_run", run, 0);
    // start: state changes 7 edges after the button rises
    button = 1'b1;
    step(6);
    check("start_early", state, 0);
    step(1);
    check("start_state", state, 1);
    check("start_run", run, 1);
    step(3);
    button = 1'b0;
    step(10);
    wait_strobe(50, n);
    check("first_strobe", n, 7);
    wait_strobe(50, n);
    check("period_00", n, 10);
    press_btn();
    check("pause_state", state, 2);
    count_strobes(500, c);
    check("pause_strobes", c, 0);
    button = 1'b1;
    step(7);
    check("resume_state", state, 1);
    wait_strobe(50, n);
    check("resume_strobe", n, 10);
    button = 1'b0;
    step(10);
    // glitch rejection
    repeat (5) begin
      button = 1'b1;
      step(3);
      button = 1'b0;
      step(7);
    end
    check("glitch3_state", state, 1);
    button = 1'b1;
    #20;
    button = 1'b0;
    step(20);
    check("glitch20_state", state, 1);
    // rate changes
    wait_strobe(50, n);
    step(3);
    freq_set = 2'b01;
    wait_strobe(300, n);
    check("rate01_first", n, 103);
    wait_strobe(300, n);
    check("rate01_period", n, 100);
    step(97);
    freq_set = 2'b10;
    wait_strobe(1000, n);
    check("rate10_tc_collide", n, 503);
    step(3);
    freq_set = 2'b11;
    wait_strobe(3000, n);
    check("rate11_first", n, 2003);
    freq_set = 2'b00;
    wait_strobe(3000, n);
    check("rate00_back", n, 13);
    // direction
    step(3);
    dir_set = 1'b0;
    step(1);
    check("dir_lag", shift_dir, 1);
    step(1);
    check("dir_follow", shift_dir, 0);
    wait_strobe(50, n);
    check("dir_phase", n, 5);
    check("dir_at_strobe", shift_dir, 0);
    dir_set = 1'b1;
    // press accepted in the terminal-count cycle
    step(3);
    button = 1'b1;
    step(6);
    check("collide_pre", state, 1);
    step(1);
    check("collide_state", state, 2);
    check("collide_en", shift_en, 0);
    step(3);
    button = 1'b0;
    count_strobes(20, c);
    check("collide_strobes", c, 0);
    button = 1'b1;
    step(7);
    check("rerun_state", state, 1);
    button = 1'b0;
    wait_strobe(50, n);
    check("rerun_strobe", n, 10);
    // reset mid-run at a terminal count
    step(9);
    rst = 1'b1;
    step(1);
    check("midrst_state", state, 0);
    check("midrst_en", shift_en, 0);
    check("midrst_run", run, 0);
    rst = 1'b0;
    count_strobes(50, c);
    check("postrst_strobes", c, 0);
    check("postrst_state", state, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/led_run_ctrl.md
# led_run_ctrl

Run/stop and rate controller for the 8-bit LED shifter. It debounces the start/stop button, keeps the run state, and divides the 100 MHz system clock into single-cycle shift strobes at 1000/100/20/5 Hz selected by `freq_set`. Each strobe carries the current direction. It sits between the board switches/button and the LED shift register, and owns all timing decisions for that shifter.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency. Divisors derive from it; the bench overrides it to shorten runs.
- `DEB_CYCLES`, default 1_000_000 (10 ms): number of stable cycles required before the debounced button level changes.
- `clk` input 1: system clock, single clock domain.
- `rst` input 1: reset, synchronous and active-high.
- `button` input 1: raw start/stop pushbutton, asynchronous, active-high.
- `freq_set` input 2: rate select, asynchronous switches. 00 = 1000 Hz, 01 = 100 Hz, 10 = 20 Hz, 11 = 5 Hz.
- `dir_set` input 1: direction switch, asynchronous. 1 = left, 0 = right.
- `shift_en` output 1: one-cycle strobe; the shifter moves one position.
- `shift_dir` output 1: direction to apply with `shift_en`. 1 = left.
- `state` output 2: 00 IDLE, 01 RUN, 10 PAUSE.
- `run` output 1: high when `state` is RUN.

## Operation
- **Input synchronisation:** `button`, `freq_set` and `dir_set` each pass through two-flop synchronisers before any use.
- **Debounce:**
  - Keep a debounced level, reset value 0.
  - When the synced button differs from the debounced level for `DEB_CYCLES` consecutive cycles, update the debounced level.
  - Any mismatch-free cycle clears the stability count.
  - `press` is a one-cycle internal pulse on a 0→1 change of the debounced level. Releases produce nothing.
- **FSM:**
  - IDLE→RUN on `press`.
  - RUN→PAUSE on `press`.
  - PAUSE→RUN on `press`.
  - No other transitions.
- **Divisor:**
  - DIV = `CLK_HZ`/1000, /100, /20 or /5, selected by the synced `freq_set`.
  - Divisor values are integer; the tick counter is 25 bits wide, which is enough for 20_000_000.
- **Tick counter:**
  - In RUN, increment each cycle.
  - At DIV−1, assert `shift_en` and wrap to 0.
  - In IDLE and PAUSE, hold at 0 with no strobes.
  - Clear to 0 on every entry into RUN, so the first strobe comes exactly DIV cycles after the state change.
- **Rate change:** any change of the synced `freq_set` (compared against a registered copy) clears the counter that cycle. The new DIV applies from the next cycle, and no `shift_en` is issued in the change cycle.
- **Direction:** `shift_dir` loads the synced `dir_set` on every cycle. It is therefore valid alongside any `shift_en`, and direction changes take effect at the next strobe.
- **Simultaneous events:**
  - `press` and the terminal count in the same cycle: `press` wins, the state leaves RUN, and no strobe is issued.
  - Rate change and terminal count in the same cycle: no strobe, and the counter clears.
- **Reset:**
  - Reset at any time, including mid-run, takes effect at the next edge.
  - state = IDLE, `run` = 0, `shift_en` = 0, `shift_dir` = 1.
  - Counter, debounced level, stability count and synchroniser flops = 0.
  - `freq_set` registered copy = 00.

## Timing
- **Button to state:** the button rises at edge 0; synced high after 2 edges; debounced high after a further `DEB_CYCLES` edges; `state` updates on the next edge. Latency is `DEB_CYCLES`+3 cycles.
- **State to strobe:** first `shift_en` is DIV cycles after `state` becomes RUN. Strobes then repeat every DIV cycles while RUN holds and `freq_set` is stable.
- **Outputs:** `shift_en` and `shift_dir` are registered outputs, with no combinational path from inputs.
- **Switch latency:** `freq_set` and `dir_set` act 2 cycles after the switch moves (synchroniser depth).

## Structure
- Package `led_pkg`:
  - state encoding constants IDLE/RUN/PAUSE.
  - rate code constants.
  - function `rate_div(code, clk_hz)` returning the 25-bit divisor.
  - `DIR_LEFT` = 1.
- Sub-module `btn_debounce` (parameter `DEB_CYCLES`; ports `clk`, `rst`, `din`, `level`, `rise`): contains the synchroniser, stability counter and rising-edge pulse.
- Top level holds the FSM, tick counter and rate-change detector.

## Test plan
All scenarios use `CLK_HZ`=10_000 (DIV = 10/100/500/2000) and `DEB_CYCLES`=4.

1. **Reset and idle:** `rst` high for 5 cycles, then idle for 200 cycles → `state`=00, `shift_en` never high, `shift_dir`=1.
2. **Start and stop:** hold `button` high for 10 cycles with `freq_set`=00 → `state`=01 exactly 7 cycles after the rise, then `shift_en` pulses every 10 cycles. A second press → `state`=10, with no strobes for 500 cycles; a third press → RUN, first strobe 10 cycles later.
3. **Glitch rejection:** 3-cycle `button` pulses every 10 cycles → `state` unchanged. A 20 ns pulse as in the legacy bench → also rejected.
4. **Rate change:** in RUN, switch `freq_set` 00→01 at counter value 5 → no strobe in the change cycle, next strobe 100 cycles after the change takes effect. Repeat for 10 (500 cycles) and 11 (2000 cycles).
5. **Direction:** toggle `dir_set` mid-period → `shift_dir` follows 2 cycles after the toggle and is valid at the next strobe. Counter phase is unaffected.
6. **Collisions and reset:** a press accepted in the terminal-count cycle → no strobe, `state`=10. `rst` asserted mid-RUN → IDLE with `shift_en`=0 at the next edge.
